cle_sram_arbiter: RTL and testbench
===================================

# cle_sram_arbiter

Two-requester arbiter for the single-port 1024x8 label SRAM in the component labeling engine. The raster-scan labeler (port 0) and the label-merge/relabel pass (port 1) both need SRAM access. This block grants one access per cycle using round-robin with optional burst locking. It drives the SRAM address, data and write-enable, and routes the one-cycle-late read data back to the requester that issued the read.

## Interface
Parameters:
- AW, 10, SRAM address width (1024 words)
- DW, 8, SRAM data width
- BURST_MAX, 16, maximum consecutive locked grants before a contending requester is served

Ports:
- clk  input  1  system clock, all registers on posedge
- reset  input  1  asynchronous, active-high; clears all state
- req0 / req1  input  1  access request, held until granted
- lock0 / lock1  input  1  with req, asks to keep ownership for the next cycle
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  AW  word address
- wdata0 / wdata1  input  DW  write data
- gnt0 / gnt1  output  1  access issued this cycle (combinational)
- rvalid0 / rvalid1  output  1  read data valid for the owner (registered)
- rdata  output  DW  read data, equal to sram_q, shared by both ports
- sram_q  input  DW  SRAM read data
- sram_a  output  AW  SRAM address
- sram_d  output  DW  SRAM write data
- sram_wen  output  1  active-low SRAM write enable
- busy  output  1  1 while in an OWN state

## Operation
- States: ARB, OWN0, OWN1.
- ARB:
  - Only one of req0/req1 high: that port is granted.
  - Both high: grant the port opposite to last_gnt (reset value of last_gnt = 1, so port 0 wins first).
  - If the granted port also has its lock high, go to OWN0 or OWN1 and set burst_cnt = 1.
- OWNn:
  - Port n is granted whenever reqn = 1; the other port gets no grant.
  - The state is left for ARB when reqn & lockn = 0 in a cycle.
  - The state is also left for ARB when burst_cnt = BURST_MAX and the other port is requesting. That cycle is still port n's access.
  - burst_cnt increments on each granted cycle and saturates at BURST_MAX. It is cleared on entry to ARB.
  - If reqn drops, there is no access that cycle and the next state is ARB.
- last_gnt updates to the granted port index on every grant.
- On a grant:
  - sram_a = addrN.
  - sram_d = wdataN.
  - sram_wen = ~weN.
- With no grant: sram_a = 0, sram_d = 0, sram_wen = 1.
- A read grant in cycle k registers owner = N and rd = 1. In cycle k+1, rvalidN = 1 and rdata = sram_q.
- Writes produce no rvalid.
- gnt0 & gnt1 is never 1. rvalid0 & rvalid1 is never 1.
- Simultaneous events:
  - A read to address A in cycle k followed by a write to A in cycle k+1 returns the old data in k+1.
  - A write in cycle k followed by a read in cycle k+1 returns the new data in cycle k+2.

## Timing
- Reset asserted (async):
  - state = ARB, last_gnt = 1, burst_cnt = 0.
  - rvalid0 = rvalid1 = 0, busy = 0.
  - gnt0 = gnt1 = 0, sram_wen = 1, sram_a = 0, sram_d = 0, all forced while reset is high.
- Reset mid-operation: the pending rvalid is dropped, there is no grant, and the first grant follows the first posedge after deassertion.
- Grant latency:
  - Same cycle as req when uncontended.
  - At most 1 cycle when both request in ARB.
  - At most BURST_MAX + 1 cycles against a locking owner.
- Read latency: rvalid one cycle after gnt. Back-to-back reads give rvalid every cycle.
- Requesters hold addr, wdata and we stable while req = 1 and gnt = 0.

## Test plan
- Reset: pulse reset mid-read → rvalid0 = rvalid1 = 0 and sram_wen = 1 immediately, and gnt stays low until after deassertion.
- Single port: req0 write addr 0x155, data 0xA7, then read 0x155 the next cycle.
  - Write cycle: gnt0 = 1 and sram_wen = 0.
  - Read result, two cycles after the write: rvalid0 = 1 and rdata = 0xA7.
- Contention: req0 and req1 held high without lock for 6 cycles → grants alternate 0,1,0,1,0,1, and each rvalid follows its own read one cycle later.
- Burst: port 1 reads 0x000–0x013 with lock1 = 1 while req0 is high.
  - Cycles 1–16: gnt1 only.
  - Cycle 17: gnt0.
  - Cycle 18: gnt1 resumes.
  - busy is high during the burst.
- Idle: no requests → sram_a = 0, sram_d = 0, sram_wen = 1, busy = 0, and no rvalid.
- Random: mixed req/lock/we on both ports for 5000 cycles against a 1024x8 model.
  - No double grant.
  - Every read returns the model data.
  - No requester waits more than BURST_MAX + 1 cycles.

Source files
------------

// File: rtl/cle_sram_arbiter.sv
// Round-robin arbiter with burst locking for the 1024x8 label SRAM; grants are combinational,
// read data returns one cycle after a read grant and is flagged to whichever port issued it.
module cle_sram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int BURST_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] sram_q,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen,
  output logic          busy
);

  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          rd_q, rd_d;
  logic          owner_q, owner_d;
  logic          g0, g1;

  // Count including the current granted cycle, saturating at BURST_MAX.
  assign cnt_inc = (burst_cnt_q == CW'(BURST_MAX)) ? burst_cnt_q : burst_cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    g0          = 1'b0;
    g1          = 1'b0;

    case (state_q)
      ARB: begin
        burst_cnt_d = '0;
        if (req0 && (!req1 || last_gnt_q)) begin
          g0 = 1'b1;
        end else if (req1) begin
          g1 = 1'b1;
        end
        if (g0 && lock0) begin
          state_d     = OWN0;
          burst_cnt_d = CW'(1);
        end else if (g1 && lock1) begin
          state_d     = OWN1;
          burst_cnt_d = CW'(1);
        end
      end
      OWN0: begin
        g0          = req0;
        burst_cnt_d = cnt_inc;
        if (!(req0 && lock0) || ((cnt_inc == CW'(BURST_MAX)) && req1)) begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end
      end
      OWN1: begin
        g1          = req1;
        burst_cnt_d = cnt_inc;
        if (!(req1 && lock1) || ((cnt_inc == CW'(BURST_MAX)) && req0)) begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end
    endcase

    // Grants are suppressed for the whole time reset is high, not just at the next edge.
    if (reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end

    if (g0) begin
      last_gnt_d = 1'b0;
    end else if (g1) begin
      last_gnt_d = 1'b1;
    end
  end

  assign rd_d    = (g0 && !we0) || (g1 && !we1);
  assign owner_d = g1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      rd_q        <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_q        <= rd_d;
      owner_q     <= owner_d;
    end
  end

  assign gnt0     = g0;
  assign gnt1     = g1;
  assign sram_a   = g0 ? addr0 : (g1 ? addr1 : '0);
  assign sram_d   = g0 ? wdata0 : (g1 ? wdata1 : '0);
  assign sram_wen = g0 ? !we0 : (g1 ? !we1 : 1'b1);
  assign rvalid0  = rd_q && !owner_q;
  assign rvalid1  = rd_q && owner_q;
  assign rdata    = sram_q;
  assign busy     = (state_q != ARB);

endmodule

// File: tb/tb_cle_sram_arbiter.sv
// Directed and randomised checks of cle_sram_arbiter against a behavioural 1024x8 SRAM.
module tb_cle_sram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int BM = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata, sram_q, sram_d;
  logic [AW-1:0] sram_a;
  logic          sram_wen, busy;

  always #5 clk = ~clk;

  cle_sram_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d),
    .sram_wen(sram_wen), .busy(busy)
  );

  // Behavioural single-port SRAM: read-before-write, registered output.
  logic [DW-1:0] mem [0:1023];
  logic          clr_mem;
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      sram_q <= '0;
    end else begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      sram_q <= mem[sram_a];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] shadow [0:1023];
  logic          pend_v, pend_p, got0, got1, prev0;
  logic [DW-1:0] pend_d;
  int            w0, w1, a1, pa1;
  logic          eg0, eg1;

  initial begin
    clr_mem = 1'b1;
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = 10'h155; addr1 = '0;
    wdata0 = '0; wdata1 = '0;

    // Reset state, with req0 already high
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rv0", rvalid0, 0);
    chk("rst_rv1", rvalid1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wen", sram_wen, 1);
    chk("rst_a", sram_a, 0);
    chk("rst_d", sram_d, 0);

    // Idle
    next(); reset = 1'b0; clr_mem = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("idle_a", sram_a, 0);
    chk("idle_d", sram_d, 0);
    chk("idle_wen", sram_wen, 1);
    chk("idle_busy", busy, 0);
    chk("idle_gnt", {gnt0, gnt1}, 0);
    chk("idle_rv", {rvalid0, rvalid1}, 0);

    // Single port: write 0xA7 to 0x155, then read it back
    next(); req0 = 1'b1; we0 = 1'b1; addr0 = 10'h155; wdata0 = 8'hA7;
    @(negedge clk);
    chk("wr_gnt0", gnt0, 1);
    chk("wr_gnt1", gnt1, 0);
    chk("wr_wen", sram_wen, 0);
    chk("wr_a", sram_a, 10'h155);
    chk("wr_d", sram_d, 8'hA7);
    next(); we0 = 1'b0;
    @(negedge clk);
    chk("rd_gnt0", gnt0, 1);
    chk("rd_wen", sram_wen, 1);
    chk("wr_norv", rvalid0, 0);
    next(); req0 = 1'b0;
    @(negedge clk);
    chk("rd_rv0", rvalid0, 1);
    chk("rd_rv1", rvalid1, 0);
    chk("rd_data", rdata, 8'hA7);

    // Port 1 writes 0x3C to 0x010
    next(); req1 = 1'b1; we1 = 1'b1; addr1 = 10'h010; wdata1 = 8'h3C;
    @(negedge clk);
    chk("p1wr_gnt1", gnt1, 1);
    chk("p1wr_gnt0", gnt0, 0);

    // Contention without lock: 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      next();
      if (i == 0) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h155;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'h010;
      end
      @(negedge clk);
      chk("ct_gnt0", gnt0, (i % 2) == 0);
      chk("ct_gnt1", gnt1, (i % 2) == 1);
      if (i > 0) begin
        chk("ct_rv0", rvalid0, (i % 2) == 1);
        chk("ct_rv1", rvalid1, (i % 2) == 0);
        chk("ct_rdata", rdata, ((i % 2) == 1) ? 8'hA7 : 8'h3C);
      end
    end
    next(); req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("ct_rv1_last", rvalid1, 1);
    chk("ct_rv0_last", rvalid0, 0);
    chk("ct_rdata_last", rdata, 8'h3C);

    // Port 0 access so port 1 wins the first contended cycle of the burst
    next(); req0 = 1'b1;
    @(negedge clk);
    chk("pre_gnt0", gnt0, 1);

    // Burst: port 1 locked reads 0x000..0x013 against a waiting port 0
    for (int c = 1; c <= 22; c++) begin
      next();
      req0 = (c <= 17); we0 = 1'b0; addr0 = 10'h155; lock0 = 1'b0;
      a1 = (c <= 16) ? c - 1 : c - 2;
      req1 = (c <= 21); we1 = 1'b0; lock1 = 1'b1; addr1 = AW'(a1);
      @(negedge clk);
      eg0 = (c == 17);
      eg1 = (c <= 21) && (c != 17);
      chk("bu_gnt0", gnt0, eg0);
      chk("bu_gnt1", gnt1, eg1);
      if (c >= 2 && c <= 16) chk("bu_busy", busy, 1);
      if (c == 17) chk("bu_busy17", busy, 0);
      prev0 = (c == 1) || (c == 18);
      pa1 = (c - 1 <= 16) ? c - 2 : c - 3;
      chk("bu_rv0", rvalid0, prev0);
      chk("bu_rv1", rvalid1, !prev0);
      chk("bu_rdata", rdata, prev0 ? 8'hA7 : ((pa1 == 16) ? 8'h3C : 8'h00));
    end
    next();
    @(negedge clk);
    chk("bu_idle_busy", busy, 0);
    chk("bu_idle_rv1", rvalid1, 0);

    // Reset in the middle of a read
    next(); req0 = 1'b1; we0 = 1'b0; addr0 = 10'h155; req1 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
    chk("mr_gnt0", gnt0, 1);
    @(posedge clk); #1;
    chk("mr_pre_rv0", rvalid0, 1);
    #1; reset = 1'b1; #1;
    chk("mr_rv0", rvalid0, 0);
    chk("mr_rv1", rvalid1, 0);
    chk("mr_wen", sram_wen, 1);
    chk("mr_gnt0_rst", gnt0, 0);
    @(negedge clk);
    chk("mr_gnt0_hold", gnt0, 0);
    next(); reset = 1'b0;
    @(negedge clk);
    chk("mr_gnt0_after", gnt0, 1);
    chk("mr_rv0_after", rvalid0, 0);
    next(); req0 = 1'b0;
    @(negedge clk);
    chk("mr_rv0_final", rvalid0, 1);
    chk("mr_rdata_final", rdata, 8'hA7);

    // Random traffic against a shadow memory
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
    shadow[10'h155] = 8'hA7;
    shadow[10'h010] = 8'h3C;
    pend_v = 1'b0; pend_p = 1'b0; pend_d = '0;
    w0 = 0; w1 = 0; got0 = 1'b0; got1 = 1'b0;
    lock0 = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      next();
      if (!req0 || got0) begin
        req0 = ($urandom_range(0, 9) < 7); lock0 = 1'($urandom_range(0, 1));
        we0 = 1'($urandom_range(0, 1)); addr0 = AW'($urandom_range(0, 31));
        wdata0 = DW'($urandom);
      end
      if (!req1 || got1) begin
        req1 = ($urandom_range(0, 9) < 7); lock1 = 1'($urandom_range(0, 1));
        we1 = 1'($urandom_range(0, 1)); addr1 = AW'($urandom_range(0, 31));
        wdata1 = DW'($urandom);
      end
      @(negedge clk);
      chk("rn_dbl", gnt0 & gnt1, 0);
      chk("rn_spur", (gnt0 & !req0) | (gnt1 & !req1), 0);
      chk("rn_rvdbl", rvalid0 & rvalid1, 0);
      chk("rn_rv0", rvalid0, pend_v && !pend_p);
      chk("rn_rv1", rvalid1, pend_v && pend_p);
      if (pend_v) chk("rn_rdata", rdata, pend_d);
      pend_v = 1'b0;
      if (gnt0) begin
        chk("rn_a0", sram_a, addr0);
        chk("rn_wen0", sram_wen, !we0);
        chk("rn_wait0", w0 <= BM + 1, 1);
        w0 = 0;
        if (we0) shadow[addr0] = wdata0;
        else begin pend_v = 1'b1; pend_p = 1'b0; pend_d = shadow[addr0]; end
      end else if (req0) begin
        w0++;
      end
      if (gnt1) begin
        chk("rn_a1", sram_a, addr1);
        chk("rn_wen1", sram_wen, !we1);
        chk("rn_wait1", w1 <= BM + 1, 1);
        w1 = 0;
        if (we1) shadow[addr1] = wdata1;
        else begin pend_v = 1'b1; pend_p = 1'b1; pend_d = shadow[addr1]; end
      end else if (req1) begin
        w1++;
      end
      if (!gnt0 && !gnt1) chk("rn_idle_wen", sram_wen, 1);
      got0 = gnt0;
      got1 = gnt1;
    end
    chk("rn_wait0_end", w0 <= BM + 1, 1);
    chk("rn_wait1_end", w1 <= BM + 1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
